cp0_exc_ctrl: RTL and testbench
===============================

Name: cp0_exc_ctrl

Overview:
- Coprocessor-0 exception controller. Sits at the M stage and produces the exception and EPC signals that the next-PC unit consumes; it consumes eret.
- Holds the SR, Cause, EPC and PrID registers and services mfc0/mtc0.
- Arbitrates hardware interrupts against synchronous exceptions.
- Asserting exception makes the next-PC unit jump to 0x0000_4180 and the pipeline flush; eret returns via epc_out.

Parameters:
- PRID, 32'h0000_2017, value returned on reads of register 15.
- HWINT_W, 6, number of hardware interrupt lines.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- rd_addr  in  5  mfc0 source register number.
- wr_addr  in  5  mtc0 destination register number.
- wr_data  in  32  mtc0 data.
- we  in  1  mtc0 write enable.
- pc_m  in  32  PC of the instruction currently in M.
- bd_m  in  1  that instruction is in a branch delay slot.
- exc_code_m  in  5  pending synchronous exception code; 0 means none.
- eret  in  1  eret is in M.
- hwint  in  HWINT_W  level-sensitive device interrupt lines.
- rd_data  out  32  mfc0 result.
- exception  out  1  take exception this cycle.
- epc_out  out  32  return address for eret.

Behaviour:
- Interface (decided): clock clk; reset is synchronous and active-high.
- Register fields:
  - SR(12): IM = [15:10], EXL = [1], IE = [0]; all other bits read 0.
  - Cause(13): BD = [31], IP = [15:10], ExcCode = [6:2]; all other bits read 0.
  - EPC(14): bits [1:0] always 0.
  - PrID(15): constant PRID.
- Reset: SR, Cause and EPC all clear to 0. Consequently exception = 0 and epc_out = 0 after reset. rd_data follows rd_addr.
- Requests (combinational):
  - int_req = |(hwint & IM) & IE & ~EXL
  - exc_req = (exc_code_m != 0) & ~EXL
  - exception = int_req | exc_req, valid in the same cycle as its inputs (0 cycles latency).
- Priority: interrupt beats synchronous exception. When both are pending, the recorded ExcCode is 0 (Int).
- On a clock edge with exception = 1:
  - EXL <= 1.
  - ExcCode <= int_req ? 0 : exc_code_m.
  - BD <= bd_m.
  - EPC <= bd_m ? {pc_m[31:2],2'b00} - 4 : {pc_m[31:2],2'b00}. Arithmetic is 32-bit modular: pc_m = 0 with bd_m = 1 wraps to 0xFFFF_FFFC.
- On a clock edge with eret = 1 and exception = 0: EXL <= 0. Nothing else changes.
- mtc0 (we = 1, exception = 0):
  - wr_addr 12 writes IM, EXL and IE from wr_data.
  - wr_addr 14 writes EPC with bits [1:0] forced to 0.
  - Writes to Cause, PrID and unmapped numbers are ignored.
- Collisions:
  - exception = 1 suppresses the same-cycle mtc0 and eret entirely. Exception state updates take precedence.
  - eret and mtc0 to SR in the same cycle: the mtc0 value is written, then EXL is cleared.
- IP is sampled from hwint every cycle, regardless of EXL or IE.
- rd_data is combinational from rd_addr and returns current register contents. Numbers other than 12-15 read 0. There is no write-to-read bypass on rd_data.
- epc_out = (we & wr_addr == 14 & ~exception) ? {wr_data[31:2],2'b00} : EPC. This bypass lets an eret closely following an mtc0 to EPC return correctly.
- While EXL = 1, all new interrupts and exceptions are masked; exception stays 0.
- Reset asserted during handler execution (EXL = 1) returns every register to its reset value on that edge.

Decomposition:
- Shared package/header defines:
  - Register numbers: CP0_SR = 12, CP0_CAUSE = 13, CP0_EPC = 14, CP0_PRID = 15.
  - ExcCodes: EXC_INT = 0, EXC_ADEL = 4, EXC_ADES = 5, EXC_RI = 10, EXC_OV = 12.
  - Field bit positions, and the handler entry address 32'h0000_4180.
- One natural sub-module, cp0_irq_arb: combinational int_req/exc_req/exception generation and ExcCode selection.
- Register file and update logic stay in the top module.

Test Plan:
1. Reset, then read registers 12, 13, 14, 15 -> 0, 0, 0, 0x0000_2017; exception = 0.
2. mtc0 SR = 0x0000_0401, hwint = 6'b000001 -> exception = 1 immediately. Next edge: EXL = 1, ExcCode = 0, IP = 6'b000001, EPC = pc_m (for example 0x0000_3010); exception then drops to 0.
3. exc_code_m = 12, bd_m = 1, pc_m = 0x0000_3024 with EXL = 0 -> exception = 1; EPC = 0x0000_3020, BD = 1, ExcCode = 12.
4. With EXL = 1, exc_code_m = 10 and hwint unmasked -> exception = 0; registers unchanged. Then eret -> EXL = 0 on the next edge.
5. Same cycle: hwint enabled, exc_code_m = 4, we = 1 to EPC, eret = 1 -> ExcCode = 0 and EPC = pc_m; the mtc0 is dropped and EXL = 1.
6. mtc0 EPC = 0x0000_3103 with we = 1 -> epc_out = 0x0000_3100 in the same cycle; the register holds 0x0000_3100 after the edge.

Source files
------------

// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, field positions.
package cp0_exc_ctrl_pkg;
  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int SR_IE_BIT     = 0;
  localparam int SR_EXL_BIT    = 1;
  localparam int SR_IM_LSB     = 10;
  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_BD_BIT  = 31;

  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
endpackage

// File: rtl/cp0_exc_ctrl_irq_arb.sv
// Combinational interrupt/exception arbitration; interrupts win over sync exceptions.
module cp0_irq_arb
  import cp0_exc_ctrl_pkg::*;
#(
  parameter int HWINT_W = 6
) (
  input  logic [HWINT_W-1:0] hwint,
  input  logic [HWINT_W-1:0] im,
  input  logic               ie,
  input  logic               exl,
  input  logic [4:0]         exc_code_m,
  output logic               int_req,
  output logic               exception,
  output logic [4:0]         exc_code
);
  logic exc_req;

  assign int_req   = (|(hwint & im)) & ie & ~exl;
  assign exc_req   = (exc_code_m != 5'd0) & ~exl;
  assign exception = int_req | exc_req;
  assign exc_code  = int_req ? EXC_INT : exc_code_m;
endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception controller at M: SR/Cause/EPC/PrID, mfc0/mtc0, exception and eret.
module cp0_exc_ctrl
  import cp0_exc_ctrl_pkg::*;
#(
  parameter logic [31:0] PRID    = 32'h0000_2017,
  parameter int          HWINT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         rd_addr,
  input  logic [4:0]         wr_addr,
  input  logic [31:0]        wr_data,
  input  logic               we,
  input  logic [31:0]        pc_m,
  input  logic               bd_m,
  input  logic [4:0]         exc_code_m,
  input  logic               eret,
  input  logic [HWINT_W-1:0] hwint,
  output logic [31:0]        rd_data,
  output logic               exception,
  output logic [31:0]        epc_out
);
  logic [HWINT_W-1:0] im, ip;
  logic               exl, ie, bd;
  logic [4:0]         exc_code;
  logic [31:0]        epc;

  logic               int_req;
  logic [4:0]         exc_code_sel;
  logic [31:0]        pc_al, epc_next, wr_al;
  logic               wr_sr, wr_epc;
  logic [31:0]        sr_val, cause_val;

  cp0_irq_arb #(.HWINT_W(HWINT_W)) u_arb (
    .hwint      (hwint),
    .im         (im),
    .ie         (ie),
    .exl        (exl),
    .exc_code_m (exc_code_m),
    .int_req    (int_req),
    .exception  (exception),
    .exc_code   (exc_code_sel)
  );

  assign pc_al    = pc_m & 32'hFFFF_FFFC;
  assign epc_next = bd_m ? pc_al - 32'd4 : pc_al;  // wraps modulo 2^32
  assign wr_al    = wr_data & 32'hFFFF_FFFC;
  assign wr_sr    = we & (wr_addr == CP0_SR);
  assign wr_epc   = we & (wr_addr == CP0_EPC);

  always_ff @(posedge clk) begin
    if (reset) begin
      im       <= '0;
      ip       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      exc_code <= '0;
      epc      <= '0;
    end else begin
      ip <= hwint;
      if (exception) begin
        exl      <= 1'b1;
        exc_code <= exc_code_sel;
        bd       <= bd_m;
        epc      <= epc_next;
      end else begin
        if (wr_sr) begin
          im  <= wr_data[SR_IM_LSB +: HWINT_W];
          exl <= wr_data[SR_EXL_BIT];
          ie  <= wr_data[SR_IE_BIT];
        end
        if (wr_epc) epc <= wr_al;
        // eret after a same-cycle SR write still leaves EXL clear
        if (eret) exl <= 1'b0;
      end
    end
  end

  always_comb begin
    sr_val                          = '0;
    sr_val[SR_IM_LSB +: HWINT_W]    = im;
    sr_val[SR_EXL_BIT]              = exl;
    sr_val[SR_IE_BIT]               = ie;
    cause_val                       = '0;
    cause_val[CAUSE_BD_BIT]         = bd;
    cause_val[CAUSE_IP_LSB +: HWINT_W] = ip;
    cause_val[CAUSE_EXC_LSB +: 5]   = exc_code;
    case (rd_addr)
      CP0_SR:    rd_data = sr_val;
      CP0_CAUSE: rd_data = cause_val;
      CP0_EPC:   rd_data = epc;
      CP0_PRID:  rd_data = PRID;
      default:   rd_data = '0;
    endcase
  end

  assign epc_out = (wr_epc & ~exception) ? wr_al : epc;
endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed vector bench for cp0_exc_ctrl with hand-computed expectations.
module tb_cp0_exc_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rd_addr, wr_addr, exc_code_m;
  logic [31:0] wr_data, pc_m;
  logic        we, bd_m, eret;
  logic [5:0]  hwint;
  logic [31:0] rd_data, epc_out;
  logic        exception;

  int compared = 0;
  int mismatched = 0;

  cp0_exc_ctrl dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .wr_addr(wr_addr),
    .wr_data(wr_data), .we(we), .pc_m(pc_m), .bd_m(bd_m),
    .exc_code_m(exc_code_m), .eret(eret), .hwint(hwint),
    .rd_data(rd_data), .exception(exception), .epc_out(epc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  ec;
    logic        er;
    logic [5:0]  hw;
    logic        x_exc;
    logic [31:0] x_epc;
    logic [4:0]  ra;
    logic [31:0] x_rd;
  } vec_t;

  vec_t v[20];

  function automatic vec_t mk(logic w, logic [4:0] wa, logic [31:0] wd, logic [31:0] pc,
                              logic bd, logic [4:0] ec, logic er, logic [5:0] hw,
                              logic x_exc, logic [31:0] x_epc, logic [4:0] ra, logic [31:0] x_rd);
    vec_t t;
    t.we = w; t.wa = wa; t.wd = wd; t.pc = pc; t.bd = bd; t.ec = ec; t.er = er; t.hw = hw;
    t.x_exc = x_exc; t.x_epc = x_epc; t.ra = ra; t.x_rd = x_rd;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic idle();
    we = 0; wr_addr = 0; wr_data = 0; pc_m = 0; bd_m = 0;
    exc_code_m = 0; eret = 0; hwint = 0;
  endtask

  task automatic read_chk(string name, logic [4:0] a, logic [31:0] exp);
    rd_addr = a;
    #1 chk(name, rd_data, exp);
  endtask

  initial begin
    idle();
    rd_addr = 0;
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // Reset state
    read_chk("rst_sr", 5'd12, 32'h0);
    read_chk("rst_cause", 5'd13, 32'h0);
    read_chk("rst_epc", 5'd14, 32'h0);
    read_chk("rst_prid", 5'd15, 32'h0000_2017);
    chk("rst_exc", {31'b0, exception}, 32'h0);
    chk("rst_epc_out", epc_out, 32'h0);

    //       we wa    wd            pc            bd ec    er hw     exc epc_out       ra     rd
    v[0]  = mk(1, 5'd12, 32'h0000_0401, 32'h0,        0, 5'd0, 0, 6'd0, 0, 32'h0,        5'd12, 32'h0000_0401);
    v[1]  = mk(0, 5'd0,  32'h0,         32'h0000_3010, 0, 5'd0, 0, 6'd1, 1, 32'h0,        5'd14, 32'h0000_3010);
    v[2]  = mk(0, 5'd0,  32'h0,         32'h0000_3014, 0, 5'd0, 0, 6'd1, 0, 32'h0000_3010, 5'd12, 32'h0000_0403);
    v[3]  = mk(0, 5'd0,  32'h0,         32'h0,        0, 5'd0, 1, 6'd0, 0, 32'h0000_3010, 5'd12, 32'h0000_0401);
    v[4]  = mk(0, 5'd0,  32'h0,         32'h0000_3024, 1, 5'd12,0, 6'd0, 1, 32'h0000_3010, 5'd14, 32'h0000_3020);
    v[5]  = mk(0, 5'd0,  32'h0,         32'h0,        0, 5'd0, 0, 6'd0, 0, 32'h0000_3020, 5'd13, 32'h8000_0030);
    v[6]  = mk(0, 5'd0,  32'h0,         32'h0000_3030, 0, 5'd10,0, 6'd1, 0, 32'h0000_3020, 5'd13, 32'h8000_0430);
    v[7]  = mk(0, 5'd0,  32'h0,         32'h0,        0, 5'd0, 1, 6'd0, 0, 32'h0000_3020, 5'd12, 32'h0000_0401);
    v[8]  = mk(1, 5'd14, 32'h5555_0000, 32'h0000_3040, 0, 5'd4, 1, 6'd1, 1, 32'h0000_3020, 5'd14, 32'h0000_3040);
    v[9]  = mk(0, 5'd0,  32'h0,         32'h0,        0, 5'd0, 0, 6'd1, 0, 32'h0000_3040, 5'd13, 32'h0000_0400);
    v[10] = mk(1, 5'd12, 32'h0000_0403, 32'h0,        0, 5'd0, 1, 6'd0, 0, 32'h0000_3040, 5'd12, 32'h0000_0401);
    v[11] = mk(1, 5'd14, 32'h0000_3103, 32'h0,        0, 5'd0, 0, 6'd0, 0, 32'h0000_3100, 5'd14, 32'h0000_3100);
    v[12] = mk(0, 5'd0,  32'h0,         32'h0,        1, 5'd5, 0, 6'd0, 1, 32'h0000_3100, 5'd14, 32'hFFFF_FFFC);
    v[13] = mk(0, 5'd0,  32'h0,         32'h0,        0, 5'd0, 0, 6'd0, 0, 32'hFFFF_FFFC, 5'd13, 32'h8000_0014);
    v[14] = mk(1, 5'd13, 32'hFFFF_FFFF, 32'h0,        0, 5'd0, 0, 6'd0, 0, 32'hFFFF_FFFC, 5'd13, 32'h8000_0014);
    v[15] = mk(1, 5'd15, 32'h0,         32'h0,        0, 5'd0, 0, 6'd0, 0, 32'hFFFF_FFFC, 5'd15, 32'h0000_2017);
    v[16] = mk(1, 5'd7,  32'hFFFF_FFFF, 32'h0,        0, 5'd0, 0, 6'd0, 0, 32'hFFFF_FFFC, 5'd7,  32'h0);
    v[17] = mk(0, 5'd0,  32'h0,         32'h0,        0, 5'd0, 1, 6'd0, 0, 32'hFFFF_FFFC, 5'd12, 32'h0000_0401);
    v[18] = mk(1, 5'd12, 32'h0000_0400, 32'h0,        0, 5'd0, 0, 6'd0, 0, 32'hFFFF_FFFC, 5'd12, 32'h0000_0400);
    v[19] = mk(0, 5'd0,  32'h0,         32'h0000_3050, 0, 5'd0, 0, 6'd1, 0, 32'hFFFF_FFFC, 5'd12, 32'h0000_0400);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      we = v[i].we; wr_addr = v[i].wa; wr_data = v[i].wd; pc_m = v[i].pc;
      bd_m = v[i].bd; exc_code_m = v[i].ec; eret = v[i].er; hwint = v[i].hw;
      #1;
      chk($sformatf("v%0d_exc", i), {31'b0, exception}, {31'b0, v[i].x_exc});
      chk($sformatf("v%0d_epc_out", i), epc_out, v[i].x_epc);
      @(posedge clk);
      #1 idle();
      read_chk($sformatf("v%0d_rd", i), v[i].ra, v[i].x_rd);
    end

    // Sync exception is not gated by IE; then reset while EXL=1
    @(negedge clk);
    exc_code_m = 5'd10; pc_m = 32'h0000_0100;
    #1 chk("seq_exc_no_ie", {31'b0, exception}, 32'h1);
    @(posedge clk);
    #1 idle();
    read_chk("seq_exl_set", 5'd12, 32'h0000_0402);
    @(negedge clk);
    reset = 1; hwint = 6'h3F; exc_code_m = 5'd12;
    @(posedge clk);
    #1 reset = 0; idle();
    read_chk("seq_rst_sr", 5'd12, 32'h0);
    read_chk("seq_rst_cause", 5'd13, 32'h0);
    read_chk("seq_rst_epc", 5'd14, 32'h0);
    chk("seq_rst_epc_out", epc_out, 32'h0);
    chk("seq_rst_exc", {31'b0, exception}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
